// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Bundles every signal of the MEM pipeline stage except clock and reset:
//   - the EX-side op handshake (in_valid/in_ready plus the op payload),
//   - the flush request,
//   - the data-memory bus (mem_we/mem_re/mem_a/mem_wd out, mem_rd back),
//   - the writeback record presented to WB (wb_valid/wb_regwrite/wb_rd/wb_data).
// Modports:
//   slave  - the MEM stage itself
//   master - the surrounding pipeline and data memory (or a testbench)
// -----------------------------------------------------------------------------
interface mem_access_stage_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int RW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic          in_load;
    logic          in_store;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic [DW-1:0] in_alu;
    logic          in_regwrite;
    logic [RW-1:0] in_rd;
    logic          flush;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          wb_valid;
    logic          wb_regwrite;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    modport slave (
        input  in_valid, in_load, in_store, in_addr, in_wdata, in_alu,
               in_regwrite, in_rd, flush, mem_rd,
        output in_ready, mem_we, mem_re, mem_a, mem_wd,
               wb_valid, wb_regwrite, wb_rd, wb_data
    );

    modport master (
        output in_valid, in_load, in_store, in_addr, in_wdata, in_alu,
               in_regwrite, in_rd, flush, mem_rd,
        input  in_ready, mem_we, mem_re, mem_a, mem_wd,
               wb_valid, wb_regwrite, wb_rd, wb_data
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access stage of the 8-bit pipeline. Takes one op per cycle from EX,
// drives the 256x8 data memory (1-cycle registered read) and produces the
// writeback record for WB. Loads stall the stage for one cycle (LOAD_WAIT)
// while the memory's read data comes back.
// Ports:
//   Clk  - clock
//   Rst  - synchronous active-high reset
//   bus  - mem_access_stage_if.slave (EX handshake, flush, memory bus, WB)
//   perf_loads/perf_stores/perf_stalls - saturating event counters, only
//          present when the macro MEM_STAGE_PERF_EN is defined
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int RW = 3
`ifdef MEM_STAGE_PERF_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic Clk,
    input  logic Rst,
    mem_access_stage_if.slave bus
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [CW-1:0] perf_loads,
    output logic [CW-1:0] perf_stores,
    output logic [CW-1:0] perf_stalls
`endif
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t        state_q, state_d;
    logic          wbValid_q, wbValid_d;
    logic          wbRegwrite_q, wbRegwrite_d;
    logic [RW-1:0] wbRd_q, wbRd_d;
    logic [DW-1:0] wbData_q, wbData_d;
    logic [RW-1:0] pendRd_q, pendRd_d;
    logic          pendRegwrite_q, pendRegwrite_d;

    logic          inReady;
    logic          accept;
    logic          memWe;
    logic          memRe;
    logic [AW-1:0] memA;
    logic [DW-1:0] memWd;

    // Reset is folded into in_ready so nothing is accepted while it is held.
    assign inReady = (state_q == IDLE) && !bus.flush && !Rst;
    assign accept  = bus.in_valid && inReady;

    // Next-state and memory-drive logic. A load with store also set is a
    // load only; the store half is dropped. In LOAD_WAIT the memory is idle
    // and the registered read data is forwarded into the writeback record.
    always_comb begin
        state_d        = state_q;
        wbValid_d      = 1'b0;
        wbRegwrite_d   = wbRegwrite_q;
        wbRd_d         = wbRd_q;
        wbData_d       = wbData_q;
        pendRd_d       = pendRd_q;
        pendRegwrite_d = pendRegwrite_q;
        memWe          = 1'b0;
        memRe          = 1'b0;
        memA           = bus.in_addr;
        memWd          = bus.in_wdata;

        case (state_q)
            IDLE: begin
                memRe = accept && bus.in_load;
                memWe = accept && bus.in_store && !bus.in_load;
                if (accept) begin
                    if (bus.in_load) begin
                        pendRd_d       = bus.in_rd;
                        pendRegwrite_d = bus.in_regwrite;
                        state_d        = LOAD_WAIT;
                    end else begin
                        wbValid_d    = 1'b1;
                        wbData_d     = bus.in_alu;
                        wbRd_d       = bus.in_rd;
                        wbRegwrite_d = bus.in_regwrite && !bus.in_store;
                    end
                end
            end
            LOAD_WAIT: begin
                wbValid_d    = !bus.flush;
                wbData_d     = bus.mem_rd;
                wbRd_d       = pendRd_q;
                wbRegwrite_d = pendRegwrite_q && !bus.flush;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (Rst) begin
            memWe = 1'b0;
            memRe = 1'b0;
            memA  = '0;
            memWd = '0;
        end
    end

    // State and writeback registers; reset drops any pending load.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= IDLE;
            wbValid_q      <= 1'b0;
            wbRegwrite_q   <= 1'b0;
            wbRd_q         <= '0;
            wbData_q       <= '0;
            pendRd_q       <= '0;
            pendRegwrite_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wbValid_q      <= wbValid_d;
            wbRegwrite_q   <= wbRegwrite_d;
            wbRd_q         <= wbRd_d;
            wbData_q       <= wbData_d;
            pendRd_q       <= pendRd_d;
            pendRegwrite_q <= pendRegwrite_d;
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.mem_we      = memWe;
    assign bus.mem_re      = memRe;
    assign bus.mem_a       = memA;
    assign bus.mem_wd      = memWd;
    assign bus.wb_valid    = wbValid_q;
    assign bus.wb_regwrite = wbRegwrite_q;
    assign bus.wb_rd       = wbRd_q;
    assign bus.wb_data     = wbData_q;

`ifdef MEM_STAGE_PERF_EN
    logic [CW-1:0] perfLoads_q, perfStores_q, perfStalls_q;

    // Event counters; each sticks at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            perfLoads_q  <= '0;
            perfStores_q <= '0;
            perfStalls_q <= '0;
        end else begin
            if (accept && bus.in_load && (perfLoads_q != '1))
                perfLoads_q <= perfLoads_q + 1'b1;
            if (memWe && (perfStores_q != '1))
                perfStores_q <= perfStores_q + 1'b1;
            if (bus.in_valid && !inReady && (perfStalls_q != '1))
                perfStalls_q <= perfStalls_q + 1'b1;
        end
    end

    assign perf_loads  = perfLoads_q;
    assign perf_stores = perfStores_q;
    assign perf_stalls = perfStalls_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed plus short random stimulus for mem_access_stage, with a 256x8
// registered-read data memory and a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic Clk;
    logic Rst;
    int   checkCount = 0;
    int   passCount  = 0;
    bit   checkEn    = 0;

    mem_access_stage_if #(.AW(8), .DW(8), .RW(3)) bus ();

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] perf_loads, perf_stores, perf_stalls;
    int mLoads = 0, mStores = 0, mStalls = 0;
`endif

    mem_access_stage #(.AW(8), .DW(8), .RW(3)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
`ifdef MEM_STAGE_PERF_EN
        ,
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_stalls (perf_stalls)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // External data memory: writes land at the edge, reads come back one
    // cycle after mem_re.
    logic [7:0] tbMem [256];
    always @(posedge Clk) begin
        if (bus.mem_we) tbMem[bus.mem_a] <= bus.mem_wd;
        if (bus.mem_re) bus.mem_rd <= tbMem[bus.mem_a];
    end

    // Reference model: an op either retires next cycle (non-load), or is a
    // load whose data is fetched from the model memory at accept and shows
    // up two cycles later unless killed by flush or reset. wb fields hold.
    logic [7:0] modelMem [256];
    bit         mBusy = 0;
    logic [2:0] pRd;
    logic       pRw;
    logic [7:0] pData;
    logic       expValid, expRw;
    logic [2:0] expRd;
    logic [7:0] expData;

    always @(posedge Clk) begin
        checkEn <= 1'b1;
        if (Rst) begin
            mBusy = 0;
            expValid = 0; expRw = 0; expRd = 0; expData = 0;
`ifdef MEM_STAGE_PERF_EN
            mLoads = 0; mStores = 0; mStalls = 0;
`endif
        end else begin
`ifdef MEM_STAGE_PERF_EN
            if (bus.in_valid && (mBusy || bus.flush)) mStalls++;
`endif
            if (mBusy) begin
                mBusy    = 0;
                expValid = !bus.flush;
                expData  = pData;
                expRd    = pRd;
                expRw    = pRw && !bus.flush;
            end else begin
                expValid = 0;
                if (bus.in_valid && !bus.flush) begin
                    if (bus.in_load) begin
                        pRd   = bus.in_rd;
                        pRw   = bus.in_regwrite;
                        pData = modelMem[bus.in_addr];
                        mBusy = 1;
`ifdef MEM_STAGE_PERF_EN
                        mLoads++;
`endif
                    end else begin
                        if (bus.in_store) begin
                            modelMem[bus.in_addr] = bus.in_wdata;
`ifdef MEM_STAGE_PERF_EN
                            mStores++;
`endif
                        end
                        expValid = 1;
                        expData  = bus.in_alu;
                        expRd    = bus.in_rd;
                        expRw    = bus.in_regwrite && !bus.in_store;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            passCount++;
    endtask

    // Every-cycle compare of DUT outputs against the model, half a cycle
    // after the edge so both combinational and registered outputs are stable.
    always @(negedge Clk) begin : compare
        logic expReady, expAcc;
        if (checkEn) begin
            expReady = !mBusy && !bus.flush && !Rst;
            expAcc   = bus.in_valid && expReady;
            checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
            checkOutput("mem_we", 32'(bus.mem_we), 32'(expAcc && bus.in_store && !bus.in_load));
            checkOutput("mem_re", 32'(bus.mem_re), 32'(expAcc && bus.in_load));
            if (Rst) begin
                checkOutput("mem_a_rst", 32'(bus.mem_a), 0);
                checkOutput("mem_wd_rst", 32'(bus.mem_wd), 0);
            end else if (expAcc) begin
                checkOutput("mem_a", 32'(bus.mem_a), 32'(bus.in_addr));
                if (bus.in_store && !bus.in_load)
                    checkOutput("mem_wd", 32'(bus.mem_wd), 32'(bus.in_wdata));
            end
            checkOutput("wb_valid", 32'(bus.wb_valid), 32'(expValid));
            checkOutput("wb_regwrite", 32'(bus.wb_regwrite), 32'(expRw));
            checkOutput("wb_rd", 32'(bus.wb_rd), 32'(expRd));
            checkOutput("wb_data", 32'(bus.wb_data), 32'(expData));
`ifdef MEM_STAGE_PERF_EN
            checkOutput("perf_loads", 32'(perf_loads), 32'(mLoads));
            checkOutput("perf_stores", 32'(perf_stores), 32'(mStores));
            checkOutput("perf_stalls", 32'(perf_stalls), 32'(mStalls));
`endif
        end
    end

    task automatic applyStimulus(input logic v, input logic ld, input logic st,
                                 input logic [7:0] a, input logic [7:0] wd,
                                 input logic [7:0] alu, input logic rw,
                                 input logic [2:0] rd, input logic fl);
        bus.in_valid    = v;
        bus.in_load     = ld;
        bus.in_store    = st;
        bus.in_addr     = a;
        bus.in_wdata    = wd;
        bus.in_alu      = alu;
        bus.in_regwrite = rw;
        bus.in_rd       = rd;
        bus.flush       = fl;
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0);
    endtask

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] baseLoads, baseStores, baseStalls;
`endif

    // Directed scenarios followed by a short random run.
    initial begin : stimulus
        for (int i = 0; i < 256; i++) begin
            tbMem[i]    = 8'(i) ^ 8'hA5;
            modelMem[i] = 8'(i) ^ 8'hA5;
        end
        tbMem[8'h00] = 8'h11; modelMem[8'h00] = 8'h11;
        tbMem[8'hFF] = 8'h22; modelMem[8'hFF] = 8'h22;
        tbMem[8'h30] = 8'h77; modelMem[8'h30] = 8'h77;

        $display("[TB] reset with a store presented");
        Rst = 1'b1;
        applyStimulus(1, 0, 1, 8'h44, 8'hEE, 8'h00, 1, 3'd1, 0);
        nextCycle();
        @(negedge Clk);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 0);
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 0);
        checkOutput("rst_wb_data", 32'(bus.wb_data), 0);
        nextCycle();
        @(negedge Clk);
        checkOutput("rst_mem_we2", 32'(bus.mem_we), 0);
        nextCycle();
        Rst = 1'b0;
        idle();
        @(negedge Clk);
        checkOutput("post_rst_ready", 32'(bus.in_ready), 1);
        checkOutput("mem44_untouched", 32'(tbMem[8'h44]), 32'(8'h44 ^ 8'hA5));

        $display("[TB] ALU op");
        nextCycle();
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h5A, 1, 3'd3, 0);
        nextCycle();
        idle();
        @(negedge Clk);
        checkOutput("alu_valid", 32'(bus.wb_valid), 1);
        checkOutput("alu_data", 32'(bus.wb_data), 32'h5A);
        checkOutput("alu_rd", 32'(bus.wb_rd), 3);
        checkOutput("alu_rw", 32'(bus.wb_regwrite), 1);

        $display("[TB] store then load, same address");
        nextCycle();
        applyStimulus(1, 0, 1, 8'h10, 8'hC3, 8'h10, 1, 3'd2, 0);
        @(negedge Clk);
        checkOutput("st_mem_we", 32'(bus.mem_we), 1);
        nextCycle();
        applyStimulus(1, 1, 0, 8'h10, 8'h00, 8'h10, 1, 3'd5, 0);
        @(negedge Clk);
        checkOutput("st_wb_valid", 32'(bus.wb_valid), 1);
        checkOutput("st_wb_rw", 32'(bus.wb_regwrite), 0);
        checkOutput("ld_mem_re", 32'(bus.mem_re), 1);
        nextCycle();
        @(negedge Clk);
        checkOutput("ld_stall_ready", 32'(bus.in_ready), 0);
        nextCycle();
        idle();
        @(negedge Clk);
        checkOutput("ld_valid", 32'(bus.wb_valid), 1);
        checkOutput("ld_data", 32'(bus.wb_data), 32'hC3);
        checkOutput("ld_rd", 32'(bus.wb_rd), 5);

        $display("[TB] back-to-back loads from 0x00 and 0xFF");
        nextCycle();
        applyStimulus(1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3'd1, 0);
        @(negedge Clk);
        checkOutput("b2b_re1", 32'(bus.mem_re), 1);
        nextCycle();
        applyStimulus(1, 1, 0, 8'hFF, 8'h00, 8'h00, 1, 3'd2, 0);
        @(negedge Clk);
        checkOutput("b2b_ready_wait1", 32'(bus.in_ready), 0);
        nextCycle();
        @(negedge Clk);
        checkOutput("b2b_ready2", 32'(bus.in_ready), 1);
        checkOutput("b2b_re2", 32'(bus.mem_re), 1);
        checkOutput("b2b_data1", 32'(bus.wb_data), 32'h11);
        nextCycle();
        idle();
        @(negedge Clk);
        checkOutput("b2b_ready_wait2", 32'(bus.in_ready), 0);
        checkOutput("b2b_gap_valid", 32'(bus.wb_valid), 0);
        nextCycle();
        @(negedge Clk);
        checkOutput("b2b_valid2", 32'(bus.wb_valid), 1);
        checkOutput("b2b_data2", 32'(bus.wb_data), 32'h22);

        $display("[TB] flush in LOAD_WAIT and in IDLE");
        nextCycle();
        applyStimulus(1, 1, 0, 8'h20, 8'h00, 8'h00, 1, 3'd4, 0);
        nextCycle();
        bus.flush = 1'b1;
        nextCycle();
        idle();
        @(negedge Clk);
        checkOutput("fl_wb_valid", 32'(bus.wb_valid), 0);
        checkOutput("fl_ready", 32'(bus.in_ready), 1);
        nextCycle();
        applyStimulus(1, 0, 1, 8'h21, 8'h5C, 8'h00, 1, 3'd4, 1);
        @(negedge Clk);
        checkOutput("fl_idle_we", 32'(bus.mem_we), 0);
        checkOutput("fl_idle_re", 32'(bus.mem_re), 0);
        nextCycle();
        idle();
        @(negedge Clk);
        checkOutput("fl_idle_wb_valid", 32'(bus.wb_valid), 0);

        $display("[TB] load and store both set");
        nextCycle();
`ifdef MEM_STAGE_PERF_EN
        baseLoads = perf_loads; baseStores = perf_stores; baseStalls = perf_stalls;
`endif
        applyStimulus(1, 1, 1, 8'h30, 8'h99, 8'h00, 1, 3'd6, 0);
        @(negedge Clk);
        checkOutput("ls_we", 32'(bus.mem_we), 0);
        checkOutput("ls_re", 32'(bus.mem_re), 1);
        nextCycle();
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h01, 0, 3'd0, 0);
        nextCycle();
        idle();
        @(negedge Clk);
        checkOutput("ls_mem30", 32'(tbMem[8'h30]), 32'h77);
        checkOutput("ls_data", 32'(bus.wb_data), 32'h77);
`ifdef MEM_STAGE_PERF_EN
        checkOutput("perf_ld_delta", 32'(perf_loads - baseLoads), 1);
        checkOutput("perf_st_delta", 32'(perf_stores - baseStores), 0);
        checkOutput("perf_stall_delta", 32'(perf_stalls - baseStalls), 1);
`endif

        $display("[TB] reset during LOAD_WAIT");
        nextCycle();
        applyStimulus(1, 1, 0, 8'h10, 8'h00, 8'h00, 1, 3'd6, 0);
        nextCycle();
        idle();
        Rst = 1'b1;
        nextCycle();
        Rst = 1'b0;
        @(negedge Clk);
        checkOutput("rstlw_valid", 32'(bus.wb_valid), 0);
        checkOutput("rstlw_ready", 32'(bus.in_ready), 1);
        nextCycle();
        @(negedge Clk);
        checkOutput("rstlw_valid2", 32'(bus.wb_valid), 0);

        $display("[TB] random ops");
        for (int i = 0; i < 200; i++) begin
            nextCycle();
            applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 7) * 37),
                          8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                          ($urandom_range(0, 9) == 0));
        end
        nextCycle();
        idle();
        repeat (3) nextCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
